alu_control_md: RTL and testbench
=================================

# alu_control_md

Parametrised ALU control unit for the RISC-V core with an iterative multiply/divide sequencer. It decodes `aluop`, `func3` and `func7` into the 4-bit ALU operation code for single-cycle instructions. It also detects M-extension ops (MUL, MULHU, DIVU, REMU) and computes them over multiple cycles with a shift-add/restoring engine. It sits between the control unit/register file and the ALU, and stalls the datapath while an M op runs.

## Interface
- `WIDTH`, 32, operand and result width; ≥ 2; iteration counter is `$clog2(WIDTH)+1` bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `valid`  in  1  the decode inputs and operands hold a live instruction.
- `flush`  in  1  abort any in-flight M op.
- `aluop`  in  3  class from the control unit.
- `func3`  in  3  `instr[14:12]`.
- `func7`  in  7  `instr[31:25]`.
- `op_a`, `op_b`  in  WIDTH  rs1/rs2 operands.
- `aluoperation`  out  4  ALU op code (combinational).
- `md_sel`  out  1  write-back selects `md_result` (combinational).
- `stall`  out  1  freeze PC and the instruction (combinational).
- `md_done`  out  1  registered; `md_result` valid this cycle.
- `md_result`  out  WIDTH  registered M result.
- `busy`  out  1  state is MUL or DIV.

## Operation
- **Op codes:** ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SLT 0111, PASSB 1000, ILLEGAL 1111.
- **`aluop` classes:**
  - 000 (load/store/jal/jalr/auipc/addi): ADD.
  - 010 (branch): SUB.
  - 011 (lui): PASSB.
  - 100 (I-ALU): `func3` 000 ADD, 100 XOR, 110 OR, 111 AND, 010 SLT, 001 SLL. For 101, SRL only if `func7`=0000000.
  - 111 (R-type):
    - `func7`=0000000: `func3` 000 ADD, 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND.
    - `func7`=0100000 with `func3`=000: SUB.
    - `func7`=0000001: M op. `func3` 000 MUL, 011 MULHU, 101 DIVU, 111 REMU. `aluoperation`=ADD (don't-care) and `md_sel`=1.
  - Any other combination: ILLEGAL, `md_sel`=0, no stall.
- **States:** IDLE, MUL, DIV, DONE.
  - IDLE → MUL/DIV when `valid` & M op & !`flush`. Operands are latched, counter cleared, op kind latched.
  - MUL/DIV iterate one bit per cycle for `WIDTH` cycles, then → DONE.
  - DONE → IDLE unconditionally.
- **MUL:** unsigned shift-add into a 2·`WIDTH` product. MUL returns `[WIDTH-1:0]`; MULHU returns `[2·WIDTH-1:WIDTH]`.
- **DIVU/REMU:** unsigned restoring division. Divisor 0 yields quotient all-ones and remainder = dividend, with no special path needed.
- **`stall`:** `(IDLE & valid & M op & !flush) | busy`. It is low in DONE.
- **`md_result`** holds its value until the next DONE; it is cleared on reset only.
- **`flush`** in MUL/DIV/DONE → IDLE next edge, with no `md_done`. `flush` has priority over issue and completion.
- **`valid` deasserting mid-op** is ignored; the op completes.

## Timing
- **Cycle 0:** IDLE with an M op presented; `stall`=1.
- **Cycles 1..WIDTH:** MUL/DIV; `busy`=1, `stall`=1.
- **Cycle WIDTH+1:** DONE; `md_done`=1, `stall`=0. The pipeline advances at the end of this cycle.
- Stall lasts WIDTH+1 cycles (33 for the default).
- Non-M instructions have zero latency and never stall.
- A back-to-back M op is accepted in the IDLE cycle after DONE.
- **Reset values:** state IDLE; `md_done`, `busy`, `md_result` = 0; counter and operand registers = 0.
- Reset mid-op aborts the op with no `md_done`.

## Configuration
- **`ALUCTRL_DIV_EN` defined:** DIVU/REMU decode and execute as above.
- **Undefined:** no divide datapath or DIV state is synthesised. `func7`=0000001 with `func3` 101/111 decodes as ILLEGAL: `md_sel`=0, no stall. MUL/MULHU are unaffected.

## Test plan
- R-type with `aluop`=111, `func3`=000, `func7`=0100000 → `aluoperation`=0001, `stall`=0. `aluop`=100, `func3`=101, `func7`=0100000 → 1111.
- MUL 7×6, issued at cycle 0 → `stall`=1 in cycles 0–32; `md_done`=1 with `md_result`=42 in cycle 33; IDLE in cycle 34.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → `md_result`=0xFFFFFFFE. A back-to-back MUL issued the next cycle completes 34 cycles later.
- DIVU 100/7 → 14, REMU 100/7 → 2, DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5. Without `ALUCTRL_DIV_EN`: DIVU → `aluoperation`=1111, `stall`=0.
- `flush` in cycle 10 of a MUL → IDLE in cycle 11, `stall`=0, no `md_done`, `md_result` unchanged.
- `reset`=0 in cycle 5 of a DIVU → next cycle IDLE, `busy`=0, `md_result`=0, no `md_done`.

Source files
------------

// File: rtl/alu_control_md.sv
// alu_control_md: ALU control decode plus an iterative multiply/divide sequencer.
// Single-cycle instructions are decoded combinationally into a 4-bit ALU op code.
// M-extension ops (MUL, MULHU, DIVU, REMU) run on a one-bit-per-cycle engine
// and hold the pipeline in stall until the result is ready.
// Optional feature macro: ALUCTRL_DIV_EN enables DIVU/REMU (restoring divider).
// Without it, only MUL/MULHU are M ops; divide encodings decode as ILLEGAL.
//
// Handshake: an M op is accepted in IDLE when valid & M op & !flush; the
// datapath must hold the instruction while stall=1. md_done pulses for one
// cycle together with a valid md_result, and stall is low in that cycle so the
// instruction retires at its end.
module alu_control_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             flush,
    input  logic [2:0]       aluop,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [3:0]       aluoperation,
    output logic             md_sel,
    output logic             stall,
    output logic             md_done,
    output logic [WIDTH-1:0] md_result,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD     = 4'b0000;
    localparam logic [3:0] OP_SUB     = 4'b0001;
    localparam logic [3:0] OP_AND     = 4'b0010;
    localparam logic [3:0] OP_OR      = 4'b0011;
    localparam logic [3:0] OP_XOR     = 4'b0100;
    localparam logic [3:0] OP_SLL     = 4'b0101;
    localparam logic [3:0] OP_SRL     = 4'b0110;
    localparam logic [3:0] OP_SLT     = 4'b0111;
    localparam logic [3:0] OP_PASSB   = 4'b1000;
    localparam logic [3:0] OP_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef ALUCTRL_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;     // MUL: {hi, lo}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]       opnd_q, opnd_d;     // multiplicand or divisor
    logic                   kind_q, kind_d;     // 1: take upper half (MULHU / REMU)
    logic                   md_done_q, md_done_d;
    logic [WIDTH-1:0]       md_result_q, md_result_d;

    logic                   m_op;
    logic                   issue;
    logic                   last_iter;
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;

    // Decode aluop/func3/func7 into the ALU op code and M-op detection.
    always_comb begin
        aluoperation = OP_ILLEGAL;
        m_op         = 1'b0;
        case (aluop)
            3'b000: aluoperation = OP_ADD;
            3'b010: aluoperation = OP_SUB;
            3'b011: aluoperation = OP_PASSB;
            3'b100: begin
                case (func3)
                    3'b000:  aluoperation = OP_ADD;
                    3'b001:  aluoperation = OP_SLL;
                    3'b010:  aluoperation = OP_SLT;
                    3'b100:  aluoperation = OP_XOR;
                    3'b101:  aluoperation = (func7 == 7'b0000000) ? OP_SRL : OP_ILLEGAL;
                    3'b110:  aluoperation = OP_OR;
                    3'b111:  aluoperation = OP_AND;
                    default: aluoperation = OP_ILLEGAL;
                endcase
            end
            3'b111: begin
                if (func7 == 7'b0000000) begin
                    case (func3)
                        3'b000:  aluoperation = OP_ADD;
                        3'b001:  aluoperation = OP_SLL;
                        3'b010:  aluoperation = OP_SLT;
                        3'b100:  aluoperation = OP_XOR;
                        3'b101:  aluoperation = OP_SRL;
                        3'b110:  aluoperation = OP_OR;
                        3'b111:  aluoperation = OP_AND;
                        default: aluoperation = OP_ILLEGAL;
                    endcase
                end else if (func7 == 7'b0100000 && func3 == 3'b000) begin
                    aluoperation = OP_SUB;
                end else if (func7 == 7'b0000001) begin
                    case (func3)
                        3'b000, 3'b011: begin
                            aluoperation = OP_ADD;
                            m_op         = 1'b1;
                        end
`ifdef ALUCTRL_DIV_EN
                        3'b101, 3'b111: begin
                            aluoperation = OP_ADD;
                            m_op         = 1'b1;
                        end
`endif
                        default: aluoperation = OP_ILLEGAL;
                    endcase
                end
            end
            default: aluoperation = OP_ILLEGAL;
        endcase
    end

    assign md_sel    = m_op;
    assign issue     = (state_q == S_IDLE) && valid && m_op && !flush;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

`ifdef ALUCTRL_DIV_EN
    assign busy = (state_q == S_MUL) || (state_q == S_DIV);
`else
    assign busy = (state_q == S_MUL);
`endif

    assign stall     = issue || busy;
    assign md_done   = md_done_q;
    assign md_result = md_result_q;
    assign dbg_state = state_q;

    // One shift-add step: add multiplicand to the high half when the low bit is set, then shift right.
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    end

`ifdef ALUCTRL_DIV_EN
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH:0]     rem_new;
    logic [2*WIDTH-1:0] div_next;

    // One restoring step: shift in the next dividend bit, subtract the divisor when it fits.
    // A zero divisor always fits, giving an all-ones quotient and the dividend as remainder.
    always_comb begin
        rem_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, opnd_q});
        rem_new  = rem_ge ? (rem_sh - {1'b0, opnd_q}) : rem_sh;
        div_next = {rem_new[WIDTH-1:0], prod_q[WIDTH-2:0], rem_ge};
    end
`endif

    // Sequencer next-state: issue, iterate, complete; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        opnd_d      = opnd_q;
        kind_d      = kind_q;
        md_done_d   = 1'b0;
        md_result_d = md_result_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    cnt_d  = '0;
                    kind_d = func3[1];
`ifdef ALUCTRL_DIV_EN
                    if (func3[2]) begin
                        state_d = S_DIV;
                        opnd_d  = op_b;
                        prod_d  = {{WIDTH{1'b0}}, op_a};
                    end else begin
                        state_d = S_MUL;
                        opnd_d  = op_a;
                        prod_d  = {{WIDTH{1'b0}}, op_b};
                    end
`else
                    state_d = S_MUL;
                    opnd_d  = op_a;
                    prod_d  = {{WIDTH{1'b0}}, op_b};
`endif
                end
            end
            S_MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d     = S_DONE;
                    md_done_d   = 1'b1;
                    md_result_d = kind_q ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
                end
            end
`ifdef ALUCTRL_DIV_EN
            S_DIV: begin
                prod_d = div_next;
                cnt_d  = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d     = S_DONE;
                    md_done_d   = 1'b1;
                    md_result_d = kind_q ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            md_done_d   = 1'b0;
            md_result_d = md_result_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prod_q      <= '0;
            opnd_q      <= '0;
            kind_q      <= 1'b0;
            md_done_q   <= 1'b0;
            md_result_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            opnd_q      <= opnd_d;
            kind_q      <= kind_d;
            md_done_q   <= md_done_d;
            md_result_q <= md_result_d;
        end
    end

endmodule

// File: tb/tb_alu_control_md.sv
// Testbench for alu_control_md: random decode against a rule-table model,
// directed and random M ops against arithmetic reference results, plus
// back-to-back issue, flush and mid-op reset scenarios.
module tb_alu_control_md;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          valid;
    logic          flush;
    logic [2:0]    aluop;
    logic [2:0]    func3;
    logic [6:0]    func7;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [3:0]    aluoperation;
    logic          md_sel;
    logic          stall;
    logic          md_done;
    logic [W-1:0]  md_result;
    logic          busy;
    logic [1:0]    dbg_state;

    int            total;
    int            passed;
    logic [W-1:0]  last_result;

`ifdef ALUCTRL_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    alu_control_md #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid        (valid),
        .flush        (flush),
        .aluop        (aluop),
        .func3        (func3),
        .func7        (func7),
        .op_a         (op_a),
        .op_b         (op_b),
        .aluoperation (aluoperation),
        .md_sel       (md_sel),
        .stall        (stall),
        .md_done      (md_done),
        .md_result    (md_result),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: {md_sel, op code} from the instruction class rules.
    function automatic logic [4:0] ref_decode(input logic [2:0] a, input logic [2:0] f3, input logic [6:0] f7);
        logic [3:0] i_map [8];
        logic [3:0] r_map [8];
        i_map = '{4'h0, 4'h5, 4'h7, 4'hF, 4'h4, 4'hF, 4'h3, 4'h2};
        r_map = '{4'h0, 4'h5, 4'h7, 4'hF, 4'h4, 4'h6, 4'h3, 4'h2};
        if (a == 3'd0) return {1'b0, 4'h0};
        if (a == 3'd2) return {1'b0, 4'h1};
        if (a == 3'd3) return {1'b0, 4'h8};
        if (a == 3'd4) begin
            if (f3 == 3'd5) return {1'b0, (f7 == 7'h00) ? 4'h6 : 4'hF};
            return {1'b0, i_map[f3]};
        end
        if (a == 3'd7) begin
            if (f7 == 7'h00) return {1'b0, r_map[f3]};
            if (f7 == 7'h20) return {1'b0, (f3 == 3'd0) ? 4'h1 : 4'hF};
            if (f7 == 7'h01) begin
                if (f3 == 3'd0 || f3 == 3'd3) return {1'b1, 4'h0};
                if (DIV_EN && (f3 == 3'd5 || f3 == 3'd7)) return {1'b1, 4'h0};
            end
        end
        return {1'b0, 4'hF};
    endfunction

    // Reference M-op result from plain wide arithmetic.
    function automatic logic [W-1:0] ref_md(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (f3)
            3'd0:    return p[W-1:0];
            3'd3:    return p[2*W-1:W];
            3'd5:    return (b == '0) ? {W{1'b1}} : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        valid = 1'b0;
        flush = 1'b0;
        aluop = 3'd0;
        func3 = 3'd0;
        func7 = 7'd0;
        op_a  = '0;
        op_b  = '0;
    endtask

    // Issue one M op at cycle 0 and follow it through to DONE at cycle W+1.
    task automatic run_md(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        logic [W-1:0] exp;
        exp = ref_md(f3, a, b);
        next_cycle();
        valid = 1'b1; flush = 1'b0; aluop = 3'd7; func7 = 7'h01; func3 = f3; op_a = a; op_b = b;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL %s c0_stall got %0b want 1", name, stall); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL %s c0_busy got %0b want 0", name, busy); else passed++;
        total++; if (md_sel !== 1'b1) $display("FAIL %s c0_md_sel got %0b want 1", name, md_sel); else passed++;
        for (int c = 1; c <= W; c++) begin
            next_cycle();
            valid = 1'($urandom_range(0, 1));
            op_a  = $urandom;
            op_b  = $urandom;
            #1;
            total++; if (busy !== 1'b1 || stall !== 1'b1 || md_done !== 1'b0)
                $display("FAIL %s run_c%0d busy/stall/done got %0b%0b%0b want 110", name, c, busy, stall, md_done);
            else passed++;
        end
        next_cycle();
        valid = 1'b0;
        #1;
        total++; if (md_done !== 1'b1) $display("FAIL %s done_flag got %0b want 1", name, md_done); else passed++;
        total++; if (stall !== 1'b0 || busy !== 1'b0) $display("FAIL %s done_stall_busy got %0b%0b want 00", name, stall, busy); else passed++;
        total++; if (dbg_state !== 2'd3) $display("FAIL %s done_state got %0d want 3", name, dbg_state); else passed++;
        total++; if (md_result !== exp) $display("FAIL %s result got %h want %h", name, md_result, exp); else passed++;
        last_result = exp;
    endtask

    task automatic check_idle(input string name);
        total++; if (dbg_state !== 2'd0 || busy !== 1'b0 || md_done !== 1'b0 || stall !== 1'b0)
            $display("FAIL %s idle state/busy/done/stall got %0d %0b%0b%0b want 0 000", name, dbg_state, busy, md_done, stall);
        else passed++;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        total++; if (md_done !== 1'b0 || busy !== 1'b0 || stall !== 1'b0)
            $display("FAIL reset flags got done=%0b busy=%0b stall=%0b want 000", md_done, busy, stall);
        else passed++;
        total++; if (md_result !== '0) $display("FAIL reset md_result got %h want 0", md_result); else passed++;
        total++; if (dbg_state !== 2'd0) $display("FAIL reset state got %0d want 0", dbg_state); else passed++;
        reset = 1'b1;
        last_result = '0;
    endtask

    task automatic test_decode_directed();
        next_cycle();
        valid = 1'b1; aluop = 3'd7; func3 = 3'd0; func7 = 7'h20;
        #1;
        total++; if (aluoperation !== 4'b0001 || stall !== 1'b0)
            $display("FAIL dec_rsub got op=%b stall=%0b want 0001 0", aluoperation, stall);
        else passed++;
        next_cycle();
        aluop = 3'd4; func3 = 3'd5; func7 = 7'h20;
        #1;
        total++; if (aluoperation !== 4'b1111) $display("FAIL dec_srai got %b want 1111", aluoperation); else passed++;
        next_cycle();
        aluop = 3'd7; func3 = 3'd5; func7 = 7'h01; op_a = 32'd5; op_b = 32'd0;
        #1;
        total++; if (aluoperation !== (DIV_EN ? 4'b0000 : 4'b1111) || stall !== DIV_EN || md_sel !== DIV_EN)
            $display("FAIL dec_divu got op=%b stall=%0b sel=%0b want %b %0b %0b", aluoperation, stall, md_sel,
                     DIV_EN ? 4'b0000 : 4'b1111, DIV_EN, DIV_EN);
        else passed++;
        flush = 1'b1;
        next_cycle();
        drive_idle();
        #1;
        check_idle("dec_after");
    endtask

    task automatic test_decode_random();
        logic [2:0] cls [6];
        logic [6:0] f7s [4];
        logic [4:0] d;
        cls = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd7, 3'd7};
        f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
        for (int i = 0; i < 200; i++) begin
            next_cycle();
            aluop = (i % 8 == 7) ? 3'($urandom) : cls[$urandom_range(0, 5)];
            func3 = 3'($urandom);
            func7 = (i % 5 == 4) ? 7'($urandom) : f7s[$urandom_range(0, 3)];
            flush = 1'($urandom_range(0, 1));
            d = ref_decode(aluop, func3, func7);
            valid = (d[4] && !flush) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            total++; if (aluoperation !== d[3:0])
                $display("FAIL dec_rand op a=%0d f3=%0d f7=%h got %b want %b", aluop, func3, func7, aluoperation, d[3:0]);
            else passed++;
            total++; if (md_sel !== d[4] || stall !== 1'b0)
                $display("FAIL dec_rand sel/stall a=%0d f3=%0d f7=%h got %0b%0b want %0b0", aluop, func3, func7, md_sel, stall, d[4]);
            else passed++;
        end
        drive_idle();
    endtask

    task automatic test_mul();
        run_md(3'd0, 32'd7, 32'd6, "mul_7x6");
        next_cycle();
        drive_idle();
        #1;
        check_idle("mul_c34");
    endtask

    task automatic test_back_to_back();
        run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        run_md(3'd0, 32'h1234_5678, 32'h0000_9ABC, "mul_b2b");
        run_md(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    endtask

`ifdef ALUCTRL_DIV_EN
    task automatic test_div();
        run_md(3'd5, 32'd100, 32'd7, "divu_100_7");
        run_md(3'd7, 32'd100, 32'd7, "remu_100_7");
        run_md(3'd5, 32'd5, 32'd0, "divu_5_0");
        run_md(3'd7, 32'd5, 32'd0, "remu_5_0");
        run_md(3'd5, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    endtask
`endif

    task automatic test_random_md();
        logic [2:0] ops [4];
        logic [2:0] f3;
        ops = '{3'd0, 3'd3, 3'd5, 3'd7};
        for (int i = 0; i < 8; i++) begin
            f3 = ops[DIV_EN ? $urandom_range(0, 3) : $urandom_range(0, 1)];
            run_md(f3, $urandom, (i == 3) ? 32'd0 : 32'($urandom >> $urandom_range(0, 31)), "md_rand");
        end
    endtask

    task automatic test_flush();
        int extra_done;
        next_cycle();
        valid = 1'b1; flush = 1'b0; aluop = 3'd7; func7 = 7'h01; func3 = 3'd0; op_a = 32'd9; op_b = 32'd11;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            valid = 1'b0;
            flush = (c == 10);
        end
        #1;
        total++; if (busy !== 1'b1) $display("FAIL flush c10_busy got %0b want 1", busy); else passed++;
        next_cycle();
        flush = 1'b0;
        #1;
        check_idle("flush_c11");
        total++; if (md_result !== last_result) $display("FAIL flush md_result got %h want %h", md_result, last_result); else passed++;
        extra_done = 0;
        for (int c = 0; c < 30; c++) begin
            next_cycle();
            if (md_done === 1'b1 || busy === 1'b1) extra_done++;
        end
        total++; if (extra_done !== 0) $display("FAIL flush later_activity got %0d want 0", extra_done); else passed++;
    endtask

    task automatic test_reset_mid_op();
        next_cycle();
        valid = 1'b1; flush = 1'b0; aluop = 3'd7; func7 = 7'h01;
        func3 = DIV_EN ? 3'd5 : 3'd0; op_a = 32'd1000; op_b = 32'd3;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            valid = 1'b0;
        end
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        #1;
        check_idle("rst_mid");
        total++; if (md_result !== '0) $display("FAIL rst_mid md_result got %h want 0", md_result); else passed++;
        last_result = '0;
        run_md(3'd0, 32'd3, 32'd5, "mul_after_rst");
    endtask

    // scoreboard summary / sequencing
    initial begin
        total  = 0;
        passed = 0;
        drive_idle();
        test_reset();
        test_decode_directed();
        test_decode_random();
        test_mul();
        test_back_to_back();
`ifdef ALUCTRL_DIV_EN
        test_div();
`endif
        test_random_md();
        test_flush();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
